// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: line levels, FSM state encodings
// (identical to the receiver's) and the prescale counter width.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } tx_state_e;

  localparam int   PRESCALE_W = 5;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Load/shift register for one UART frame payload: emits data LSB first,
// tracks the bit index and holds the parity bit computed at load time.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  par_typ,
  output logic                  ser_bit,
  output logic                  parity_bit,
  output logic                  last_bit
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_IDX = BIT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shreg_d, shreg_q;
  logic                  parity_d, parity_q;
  logic [BIT_W-1:0]      bit_idx_d, bit_idx_q;

  always_comb begin
    shreg_d   = shreg_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    if (load) begin
      shreg_d   = din;
      parity_d  = (^din) ^ par_typ;
      bit_idx_d = '0;
    end else if (shift_en) begin
      shreg_d = shreg_q >> 1;
      // Saturate at the last index so the counter can never wrap back into bit 0.
      if (bit_idx_q != LAST_IDX) begin
        bit_idx_d = bit_idx_q + BIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    shreg_q  <= shreg_d;
    parity_q <= parity_d;
    if (!rst) begin
      bit_idx_q <= '0;
    end else begin
      bit_idx_q <= bit_idx_d;
    end
  end

  assign ser_bit    = shreg_q[0];
  assign parity_bit = parity_q;
  assign last_bit   = (bit_idx_q == LAST_IDX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a byte with parity config and sends
// start, data (LSB first), optional parity and stop, each held prescale clocks.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int   DATA_WIDTH = 8,
  parameter logic START_BIT  = LINE_START,
  parameter logic STOP_BIT   = LINE_STOP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  function automatic logic [PRESCALE_W-1:0] norm_prescale(input logic [PRESCALE_W-1:0] ps);
    return (ps == '0) ? PRESCALE_W'(1) : ps;
  endfunction

  tx_state_e             state_d, state_q;
  logic [PRESCALE_W-1:0] tick_d, tick_q;
  logic [PRESCALE_W-1:0] prescale_d, prescale_q;
  logic                  par_en_d, par_en_q;
  logic                  tx_out_d, tx_out_q;
  logic                  busy_d, busy_q;

  logic load;
  logic shift_en;
  logic tick_last;
  logic ser_bit;
  logic parity_bit;
  logic last_bit;

  uart_tx_serializer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_serializer (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .shift_en   (shift_en),
    .din        (P_DATA),
    .par_typ    (PAR_TYP),
    .ser_bit    (ser_bit),
    .parity_bit (parity_bit),
    .last_bit   (last_bit)
  );

  assign tick_last = (tick_q == (prescale_q - PRESCALE_W'(1)));

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    prescale_d = prescale_q;
    par_en_d   = par_en_q;
    load       = 1'b0;
    shift_en   = 1'b0;

    if (state_q == ST_IDLE) begin
      tick_d = '0;
      if (Data_Valid) begin
        load       = 1'b1;
        prescale_d = norm_prescale(prescale);
        par_en_d   = PAR_EN;
        state_d    = ST_START;
      end
    end else begin
      tick_d = tick_last ? '0 : tick_q + PRESCALE_W'(1);
      if (tick_last) begin
        case (state_q)
          ST_START: state_d = ST_DATA;
          ST_DATA: begin
            shift_en = 1'b1;
            if (last_bit) begin
              state_d = par_en_q ? ST_PAR : ST_STOP;
            end
          end
          ST_PAR:  state_d = ST_STOP;
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // Line and busy are registered from the current state, so the start bit
  // appears one edge after the accept edge.
  always_comb begin
    tx_out_d = STOP_BIT;
    busy_d   = 1'b1;
    case (state_q)
      ST_IDLE: begin
        tx_out_d = STOP_BIT;
        busy_d   = 1'b0;
      end
      ST_START: tx_out_d = START_BIT;
      ST_DATA:  tx_out_d = ser_bit;
      ST_PAR:   tx_out_d = parity_bit;
      default:  tx_out_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      tick_q   <= '0;
      tx_out_q <= STOP_BIT;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
    end
    prescale_q <= prescale_d;
    par_en_q   <= par_en_d;
  end

  assign TX_OUT = tx_out_q;
  assign busy   = busy_q;

endmodule
